// File: rtl/init_seq_pkg.sv
// Shared types and helpers for the init_sequencer power-on sequencer.
package init_seq_pkg;

  localparam int MAX_STAGES = 8;
  localparam int IDX_W      = $clog2(MAX_STAGES);

  typedef enum logic [2:0] {
    WAIT_INIT = 3'd0,
    RELEASE   = 3'd1,
    GAP       = 3'd2,
    WAIT_ACK  = 3'd3,
    RUN       = 3'd4,
    FAULT     = 3'd5
  } state_t;

  // Width needed to hold the largest wait count of the three phases.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/init_seq_counter.sv
// Synchronous-clear, saturating up-counter shared by all wait phases.
// done is high while the count equals the phase limit; the count then holds.
module init_seq_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         done
);

  logic [W-1:0] count_r;

  // Count up while enabled, stop at the limit, clear on request.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= {W{1'b0}};
    end else if (clr) begin
      count_r <= {W{1'b0}};
    end else if (en && (count_r != limit)) begin
      count_r <= count_r + W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign done = (count_r == limit);

endmodule

// File: rtl/init_sequencer.sv
// Power-on / reset sequencer: holds stage enables low after reset, then
// releases them one at a time (fixed gap or per-stage ack), then raises
// ready / clk_en. Optional macro INIT_SEQ_TIMEOUT_EN adds an ack timeout
// that drops all enables and raises fault.
// Each stage is released on the edge that enters RELEASE, so the gap and
// timeout limits are reduced by the cycle spent in RELEASE.
module init_sequencer
  import init_seq_pkg::*;
#(
  parameter int                    INIT_CYCLES = 255,
  parameter int                    NUM_STAGES  = 3,
  parameter int                    STAGE_GAP   = 16,
  parameter logic [NUM_STAGES-1:0] ACK_MASK    = 3'b000,
  parameter int                    ACK_TIMEOUT = 1023
) (
  input  logic                  clk_in,
  input  logic                  rst,
  input  logic                  restart,
  input  logic [NUM_STAGES-1:0] stage_ack,
  output logic [NUM_STAGES-1:0] stage_en,
  output logic                  ready,
  output logic                  clk_en,
  output logic                  busy,
  output logic                  fault
);

  localparam int CNT_W = cnt_width(INIT_CYCLES, STAGE_GAP, ACK_TIMEOUT);
  localparam logic [CNT_W-1:0] INIT_LIM = CNT_W'(INIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LIM  = CNT_W'((STAGE_GAP >= 2) ? STAGE_GAP - 2 : 0);
  localparam logic [CNT_W-1:0] ACK_LIM  = CNT_W'((ACK_TIMEOUT >= 2) ? ACK_TIMEOUT - 2 : 0);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);

  state_t                  state_r, state_s;
  logic [IDX_W-1:0]        cur_r, cur_s;
  logic                    ack_q_r, ack_q_s;
  logic [NUM_STAGES-1:0]   en_s;
  logic                    ready_s, busy_s;
  logic                    mask_cur_s, ack_cur_s;
  logic                    cnt_clr_s, cnt_en_s, cnt_done_s;
  logic [CNT_W-1:0]        cnt_limit_s;

  // Pick the mask bit and the masked ack of the stage currently pointed at.
  always_comb begin
    mask_cur_s = 1'b0;
    ack_cur_s  = 1'b0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (cur_r == IDX_W'(i)) begin
        mask_cur_s = ACK_MASK[i];
        ack_cur_s  = stage_ack[i] & ACK_MASK[i];
      end else begin
        mask_cur_s = mask_cur_s;
        ack_cur_s  = ack_cur_s;
      end
    end
  end

  // Next-state, stage index and next output values.
  always_comb begin
    state_s = state_r;
    cur_s   = cur_r;
    case (state_r)
      WAIT_INIT: begin
        if (cnt_done_s) begin
          state_s = RELEASE;
          cur_s   = {IDX_W{1'b0}};
        end else begin
          state_s = WAIT_INIT;
        end
      end
      RELEASE: begin
        if (mask_cur_s) begin
          state_s = WAIT_ACK;
        end else if (STAGE_GAP == 1) begin
          if (cur_r == LAST_IDX) begin
            state_s = RUN;
          end else begin
            state_s = RELEASE;
            cur_s   = cur_r + IDX_W'(1);
          end
        end else begin
          state_s = GAP;
        end
      end
      GAP: begin
        if (cnt_done_s) begin
          if (cur_r == LAST_IDX) begin
            state_s = RUN;
          end else begin
            state_s = RELEASE;
            cur_s   = cur_r + IDX_W'(1);
          end
        end else begin
          state_s = GAP;
        end
      end
      WAIT_ACK: begin
        if (ack_q_r) begin
          if (cur_r == LAST_IDX) begin
            state_s = RUN;
          end else begin
            state_s = RELEASE;
            cur_s   = cur_r + IDX_W'(1);
          end
`ifdef INIT_SEQ_TIMEOUT_EN
        end else if (cnt_done_s) begin
          state_s = FAULT;
`endif
        end else begin
          state_s = WAIT_ACK;
        end
      end
      RUN: begin
        if (restart) state_s = WAIT_INIT;
        else         state_s = RUN;
      end
      FAULT: begin
        if (restart) state_s = WAIT_INIT;
        else         state_s = FAULT;
      end
      default: begin
        state_s = WAIT_INIT;
        cur_s   = {IDX_W{1'b0}};
      end
    endcase

    case (state_s)
      WAIT_INIT, FAULT: en_s = {NUM_STAGES{1'b0}};
      RUN:              en_s = {NUM_STAGES{1'b1}};
      RELEASE: begin
        for (int i = 0; i < NUM_STAGES; i++) begin
          en_s[i] = stage_en[i] | (cur_s == IDX_W'(i));
        end
      end
      default:          en_s = stage_en;
    endcase

    ready_s = (state_s == RUN);
    busy_s  = (state_s == WAIT_INIT) || (state_s == RELEASE) ||
              (state_s == GAP) || (state_s == WAIT_ACK);
    // Ack is only captured while waiting on it; it is dropped on exit.
    ack_q_s = ((state_r == WAIT_ACK) && (state_s == WAIT_ACK)) ? ack_cur_s : 1'b0;
  end

  // Counter control: clear on every state change, count only in wait phases.
  always_comb begin
    cnt_clr_s = (state_s != state_r);
    cnt_en_s  = (state_r == WAIT_INIT) || (state_r == GAP) || (state_r == WAIT_ACK);
    case (state_r)
      GAP:      cnt_limit_s = GAP_LIM;
      WAIT_ACK: cnt_limit_s = ACK_LIM;
      default:  cnt_limit_s = INIT_LIM;
    endcase
  end

  init_seq_counter #(.W(CNT_W)) u_counter (
    .clk   (clk_in),
    .rst   (rst),
    .clr   (cnt_clr_s),
    .en    (cnt_en_s),
    .limit (cnt_limit_s),
    .done  (cnt_done_s)
  );

  // State, index and registered outputs.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_r  <= WAIT_INIT;
      cur_r    <= {IDX_W{1'b0}};
      ack_q_r  <= 1'b0;
      stage_en <= {NUM_STAGES{1'b0}};
      ready    <= 1'b0;
      clk_en   <= 1'b0;
      busy     <= 1'b1;
    end else begin
      state_r  <= state_s;
      cur_r    <= cur_s;
      ack_q_r  <= ack_q_s;
      stage_en <= en_s;
      ready    <= ready_s;
      clk_en   <= ready_s;
      busy     <= busy_s;
    end
  end

`ifdef INIT_SEQ_TIMEOUT_EN
  // Fault flag is high exactly while the FSM sits in FAULT.
  always_ff @(posedge clk_in) begin
    if (rst) fault <= 1'b0;
    else     fault <= (state_s == FAULT);
  end
`else
  assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_init_sequencer.sv
// Scoreboard bench for init_sequencer: stimulus pushes expected output
// changes {stage_en, ready, clk_en, busy, fault} with their cycle numbers;
// a negedge monitor pops one entry per observed change and compares.
module tb_init_sequencer;

  typedef struct {
    int         cyc;
    logic [6:0] val;
  } exp_t;

  logic clk = 1'b0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  exp_t       q[3][$];
  logic [6:0] prev[3];
  logic       seen[3];

  // DUT A: ACK_MASK=0
  logic rst_a, restart_a;
  logic [2:0] ack_a, en_a;
  logic ready_a, clk_en_a, busy_a, fault_a;
  // DUT B: ACK_MASK=3'b010
  logic rst_b, restart_b;
  logic [2:0] ack_b, en_b;
  logic ready_b, clk_en_b, busy_b, fault_b;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  init_sequencer #(.INIT_CYCLES(10), .NUM_STAGES(3), .STAGE_GAP(4), .ACK_MASK(3'b000)) dut_a (
    .clk_in(clk), .rst(rst_a), .restart(restart_a), .stage_ack(ack_a),
    .stage_en(en_a), .ready(ready_a), .clk_en(clk_en_a), .busy(busy_a), .fault(fault_a));

  init_sequencer #(.INIT_CYCLES(10), .NUM_STAGES(3), .STAGE_GAP(4), .ACK_MASK(3'b010)) dut_b (
    .clk_in(clk), .rst(rst_b), .restart(restart_b), .stage_ack(ack_b),
    .stage_en(en_b), .ready(ready_b), .clk_en(clk_en_b), .busy(busy_b), .fault(fault_b));

`ifdef INIT_SEQ_TIMEOUT_EN
  // DUT C: ack stage 0 with a short timeout
  logic rst_c, restart_c;
  logic [2:0] ack_c, en_c;
  logic ready_c, clk_en_c, busy_c, fault_c;
  init_sequencer #(.INIT_CYCLES(10), .NUM_STAGES(3), .STAGE_GAP(4), .ACK_MASK(3'b001),
                   .ACK_TIMEOUT(8)) dut_c (
    .clk_in(clk), .rst(rst_c), .restart(restart_c), .stage_ack(ack_c),
    .stage_en(en_c), .ready(ready_c), .clk_en(clk_en_c), .busy(busy_c), .fault(fault_c));
`endif

  // Expected observable vector; clk_en must mirror ready.
  function automatic logic [6:0] v(input logic [2:0] en, input logic rdy, input logic bsy,
                                   input logic flt);
    return {en, rdy, rdy, bsy, flt};
  endfunction

  task automatic expect_ev(input int d, input int c, input logic [6:0] val);
    exp_t e;
    e.cyc = c;
    e.val = val;
    q[d].push_back(e);
  endtask

  task automatic observe(input int d, input logic [6:0] o);
    exp_t e;
    logic [2:0] pe;
    if (o !== prev[d]) begin
      pe = prev[d][6:4];
      checks++;
      if (q[d].size() == 0) begin
        errors++;
        $display("FAIL dut%0d unexpected change: cyc=%0d got=%b, expected no change", d, cyc, o);
      end else begin
        e = q[d].pop_front();
        if ((e.cyc != cyc) || (e.val !== o)) begin
          errors++;
          $display("FAIL dut%0d event: got cyc=%0d val=%b, expected cyc=%0d val=%b",
                   d, cyc, o, e.cyc, e.val);
        end
      end
      if (seen[d] && (o[6:4] != 3'b000)) begin
        checks++;
        if ((pe & ~o[6:4]) != 3'b000) begin
          errors++;
          $display("FAIL dut%0d stage_en monotonic: got %b after %b, expected superset", d, o[6:4], pe);
        end
      end
      seen[d] = 1'b1;
    end
    prev[d] = o;
  endtask

  // Monitor: sample all outputs on the inactive edge.
  always @(negedge clk) begin
    observe(0, {en_a, ready_a, clk_en_a, busy_a, fault_a});
    observe(1, {en_b, ready_b, clk_en_b, busy_b, fault_b});
`ifdef INIT_SEQ_TIMEOUT_EN
    observe(2, {en_c, ready_c, clk_en_c, busy_c, fault_c});
`endif
  end

  // Drive inputs after edge c-1 so that edge c samples them.
  task automatic to_cyc(input int c);
    while (cyc < c - 1) @(negedge clk);
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      prev[d] = 7'h7f;
      seen[d] = 1'b0;
    end
    rst_a = 1'b1; restart_a = 1'b0; ack_a = 3'b111;
    rst_b = 1'b1; restart_b = 1'b0; ack_b = 3'b101;
`ifdef INIT_SEQ_TIMEOUT_EN
    rst_c = 1'b1; restart_c = 1'b0; ack_c = 3'b000;
`endif

    // A: reset release (cycle 1 = edge 4), restart at 34, rst at 49, rst+restart 80..82
    expect_ev(0,   1, v(3'b000, 1'b0, 1'b1, 1'b0));
    expect_ev(0,  13, v(3'b001, 1'b0, 1'b1, 1'b0));
    expect_ev(0,  17, v(3'b011, 1'b0, 1'b1, 1'b0));
    expect_ev(0,  21, v(3'b111, 1'b0, 1'b1, 1'b0));
    expect_ev(0,  25, v(3'b111, 1'b1, 1'b0, 1'b0));
    expect_ev(0,  34, v(3'b000, 1'b0, 1'b1, 1'b0));
    expect_ev(0,  44, v(3'b001, 1'b0, 1'b1, 1'b0));
    expect_ev(0,  48, v(3'b011, 1'b0, 1'b1, 1'b0));
    expect_ev(0,  49, v(3'b000, 1'b0, 1'b1, 1'b0));
    expect_ev(0,  59, v(3'b001, 1'b0, 1'b1, 1'b0));
    expect_ev(0,  63, v(3'b011, 1'b0, 1'b1, 1'b0));
    expect_ev(0,  67, v(3'b111, 1'b0, 1'b1, 1'b0));
    expect_ev(0,  71, v(3'b111, 1'b1, 1'b0, 1'b0));
    expect_ev(0,  80, v(3'b000, 1'b0, 1'b1, 1'b0));
    expect_ev(0,  92, v(3'b001, 1'b0, 1'b1, 1'b0));
    expect_ev(0,  96, v(3'b011, 1'b0, 1'b1, 1'b0));
    expect_ev(0, 100, v(3'b111, 1'b0, 1'b1, 1'b0));
    expect_ev(0, 104, v(3'b111, 1'b1, 1'b0, 1'b0));
    // B: stage 1 waits for ack; early ack at 15 ignored, ack at 28 -> release at 29
    expect_ev(1,   1, v(3'b000, 1'b0, 1'b1, 1'b0));
    expect_ev(1,  13, v(3'b001, 1'b0, 1'b1, 1'b0));
    expect_ev(1,  17, v(3'b011, 1'b0, 1'b1, 1'b0));
    expect_ev(1,  29, v(3'b111, 1'b0, 1'b1, 1'b0));
    expect_ev(1,  33, v(3'b111, 1'b1, 1'b0, 1'b0));
`ifdef INIT_SEQ_TIMEOUT_EN
    // C: timeout 8 cycles after stage_en[0], restart clears fault and reruns
    expect_ev(2,   1, v(3'b000, 1'b0, 1'b1, 1'b0));
    expect_ev(2,  13, v(3'b001, 1'b0, 1'b1, 1'b0));
    expect_ev(2,  21, v(3'b000, 1'b0, 1'b0, 1'b1));
    expect_ev(2,  30, v(3'b000, 1'b0, 1'b1, 1'b0));
    expect_ev(2,  40, v(3'b001, 1'b0, 1'b1, 1'b0));
    expect_ev(2,  48, v(3'b000, 1'b0, 1'b0, 1'b1));
`endif

    to_cyc(4);
    rst_a = 1'b0; rst_b = 1'b0;
`ifdef INIT_SEQ_TIMEOUT_EN
    rst_c = 1'b0;
`endif
    to_cyc(15); ack_b = 3'b111;
    to_cyc(16); ack_b = 3'b101;
    to_cyc(28); ack_b = 3'b111;
`ifdef INIT_SEQ_TIMEOUT_EN
    to_cyc(30); restart_c = 1'b1;
    to_cyc(31); restart_c = 1'b0;
`endif
    to_cyc(34); restart_a = 1'b1;
    to_cyc(35); restart_a = 1'b0;
    to_cyc(39); restart_a = 1'b1;
    to_cyc(40); restart_a = 1'b0;
    to_cyc(49); rst_a = 1'b1;
    to_cyc(50); rst_a = 1'b0;
    to_cyc(80); rst_a = 1'b1; restart_a = 1'b1;
    to_cyc(83); rst_a = 1'b0; restart_a = 1'b0;
    to_cyc(125);

    for (int d = 0; d < 3; d++) begin
      while (q[d].size() > 0) begin
        exp_t e;
        e = q[d].pop_front();
        checks++;
        errors++;
        $display("FAIL dut%0d missing event: got none, expected cyc=%0d val=%b", d, e.cyc, e.val);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
